// File: rtl/pac_gfx_pkg.sv
// Shared types for the Pac-Man graphics path: colour struct, frightened-mode states, coordinate width.
package pac_gfx_pkg;
    localparam int COORD_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRIGHT = 2'd1,
        FLASH  = 2'd2
    } fright_state_t;
endpackage

// File: rtl/sprite_hit.sv
// Hit test for one sprite channel: is the current pixel inside the sprite box, and at which offset.
module sprite_hit
    import pac_gfx_pkg::*;
#(
    parameter int SPR_W = 8,
    parameter int SW    = $clog2(SPR_W)
) (
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic               spr_en,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               hit,
    output logic [SW-1:0]      dx,
    output logic [SW-1:0]      row
);
    logic [COORD_W:0] dx_full;
    logic [COORD_W:0] dy_full;

    // A borrow (bit COORD_W) or any bit at/above SPR_W means outside, so sprites never wrap.
    always_comb begin
        dx_full = {1'b0, draw_x} - {1'b0, spr_x};
        dy_full = {1'b0, draw_y} - {1'b0, spr_y};
        hit     = spr_en && (dx_full[COORD_W:SW] == '0) && (dy_full[COORD_W:SW] == '0);
        dx      = dx_full[SW-1:0];
        row     = dy_full[SW-1:0];
    end
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage per-pixel compositor: wall over prioritised sprites over black, with the
// frightened/flash timer that recolours ghost channels.
module sprite_compositor
    import pac_gfx_pkg::*;
#(
    parameter int          N_SPR         = 4,
    parameter int          SPR_W         = 8,
    parameter int          GHOST_BASE    = 1,
    parameter int          FRIGHT_FRAMES = 360,
    parameter int          FLASH_FRAMES  = 120,
    parameter logic [23:0] FRIGHT_RGB    = 24'h0000FF,
    parameter logic [23:0] FLASH_RGB     = 24'hFFFFFF,
    parameter logic [23:0] WALL_RGB      = 24'h0000FF
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_start,
    input  logic                            pix_valid,
    input  logic [COORD_W-1:0]              DrawX,
    input  logic [COORD_W-1:0]              DrawY,
    input  logic                            wall_on,
    input  logic [N_SPR*COORD_W-1:0]        spr_x,
    input  logic [N_SPR*COORD_W-1:0]        spr_y,
    input  logic [N_SPR-1:0]                spr_en,
    input  logic [N_SPR-1:0]                spr_mirror,
    input  logic [N_SPR*24-1:0]             spr_rgb,
    input  logic                            fright_start,
    output logic [N_SPR*$clog2(SPR_W)-1:0]  rom_addr,
    input  logic [N_SPR*SPR_W-1:0]          rom_data,
    output logic                            frightened,
    output logic [7:0]                      Red,
    output logic [7:0]                      Green,
    output logic [7:0]                      Blue,
    output logic                            rgb_valid,
    output fright_state_t                   dbg_state,
    output logic [9:0]                      dbg_cnt
);
    localparam int SW = $clog2(SPR_W);

    logic [N_SPR*COORD_W-1:0] shd_x_q, shd_x_d, shd_y_q, shd_y_d;
    logic [N_SPR-1:0]         shd_en_q, shd_en_d, shd_mirror_q, shd_mirror_d;
    logic [N_SPR*24-1:0]      shd_rgb_q, shd_rgb_d;
    logic [N_SPR*SW-1:0]      rom_addr_q, rom_addr_d, s0_dx_q, s0_dx_d;
    logic [N_SPR-1:0]         s0_hit_q, s0_hit_d;
    logic                     s0_wall_q, s0_wall_d, s0_valid_q, s0_valid_d;
    rgb_t                     rgb_q, rgb_d;
    logic                     rgb_valid_q, rgb_valid_d;
    fright_state_t            state_q, state_d;
    logic [9:0]               cnt_q, cnt_d;

    logic [N_SPR-1:0]         hit_w;
    logic [N_SPR*SW-1:0]      dx_w, row_w;
    logic [SW-1:0]            col;
    logic                     found;

    for (genvar i = 0; i < N_SPR; i++) begin : g_hit
        sprite_hit #(.SPR_W(SPR_W), .SW(SW)) u_hit (
            .spr_x  (shd_x_q[i*COORD_W +: COORD_W]),
            .spr_y  (shd_y_q[i*COORD_W +: COORD_W]),
            .spr_en (shd_en_q[i]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit_w[i]),
            .dx     (dx_w[i*SW +: SW]),
            .row    (row_w[i*SW +: SW])
        );
    end

    // Shadows and stage 0
    always_comb begin
        shd_x_d      = shd_x_q;
        shd_y_d      = shd_y_q;
        shd_en_d     = shd_en_q;
        shd_mirror_d = shd_mirror_q;
        shd_rgb_d    = shd_rgb_q;
        if (frame_start) begin
            shd_x_d      = spr_x;
            shd_y_d      = spr_y;
            shd_en_d     = spr_en;
            shd_mirror_d = spr_mirror;
            shd_rgb_d    = spr_rgb;
        end
        s0_valid_d = pix_valid;
        s0_wall_d  = wall_on & pix_valid;
        s0_hit_d   = hit_w & {N_SPR{pix_valid}};
        s0_dx_d    = dx_w;
        rom_addr_d = pix_valid ? row_w : rom_addr_q;
    end

    // Stage 1: priority mux. With SPR_W a power of 2, SPR_W-1-dx is simply ~dx.
    always_comb begin
        rgb_d = '0;
        found = 1'b0;
        col   = '0;
        if (s0_wall_q) begin
            rgb_d = WALL_RGB;
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                col = shd_mirror_q[i] ? s0_dx_q[i*SW +: SW] : ~s0_dx_q[i*SW +: SW];
                if (!found && s0_hit_q[i] && rom_data[i*SPR_W + int'(col)]) begin
                    found = 1'b1;
                    if (i >= GHOST_BASE && state_q != IDLE)
                        rgb_d = (state_q == FLASH && cnt_q[3]) ? FLASH_RGB : FRIGHT_RGB;
                    else
                        rgb_d = shd_rgb_q[i*24 +: 24];
                end
            end
        end
        if (!s0_valid_q)
            rgb_d = '0;
        rgb_valid_d = s0_valid_q;
    end

    // Frightened timer: the flash phase starts on the frame that leaves FLASH_FRAMES behind,
    // and IDLE is entered on the frame that brings the count to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fright_start) begin
            cnt_d   = 10'(FRIGHT_FRAMES);
            state_d = FRIGHT;
        end else if (frame_start) begin
            case (state_q)
                FRIGHT: begin
                    cnt_d = cnt_q - 10'd1;
                    if (cnt_q == 10'(FLASH_FRAMES))
                        state_d = FLASH;
                end
                FLASH: begin
                    cnt_d = cnt_q - 10'd1;
                    if (cnt_q == 10'd1)
                        state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            shd_x_q      <= '0;
            shd_y_q      <= '0;
            shd_en_q     <= '0;
            shd_mirror_q <= '0;
            shd_rgb_q    <= '0;
            rom_addr_q   <= '0;
            s0_dx_q      <= '0;
            s0_hit_q     <= '0;
            s0_wall_q    <= 1'b0;
            s0_valid_q   <= 1'b0;
            rgb_q        <= '0;
            rgb_valid_q  <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
        end else begin
            shd_x_q      <= shd_x_d;
            shd_y_q      <= shd_y_d;
            shd_en_q     <= shd_en_d;
            shd_mirror_q <= shd_mirror_d;
            shd_rgb_q    <= shd_rgb_d;
            rom_addr_q   <= rom_addr_d;
            s0_dx_q      <= s0_dx_d;
            s0_hit_q     <= s0_hit_d;
            s0_wall_q    <= s0_wall_d;
            s0_valid_q   <= s0_valid_d;
            rgb_q        <= rgb_d;
            rgb_valid_q  <= rgb_valid_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign frightened = (state_q != IDLE);
    assign Red        = rgb_q.r;
    assign Green      = rgb_q.g;
    assign Blue       = rgb_q.b;
    assign rgb_valid  = rgb_valid_q;
    assign dbg_state  = state_q;
    assign dbg_cnt    = cnt_q;
endmodule
